// File: rtl/counter_monitor.sv
// counter_monitor: cycle-accurate shadow model of an up/down/load counter that flags Q, rco and load mismatches.
// Optional macro MON_RESYNC_EN: after a Q mismatch the model re-baselines on the observed Q.
module counter_monitor #(
    parameter int WIDTH     = 4,
    parameter int ERR_LIMIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Q,
    input  logic             rco,
    input  logic             load,
    output logic             err_q,
    output logic             err_rco,
    output logic             err_load,
    output logic             err_sticky,
    output logic [7:0]       err_count,
    output logic [1:0]       mon_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARM   = 2'b01,
        TRACK = 2'b10,
        FAULT = 2'b11
    } state_t;

    localparam logic [WIDTH:0] ONE   = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] THREE = {{(WIDTH-1){1'b0}}, 2'b11};
    localparam logic [7:0]     LIMIT = ERR_LIMIT[7:0];

    state_t           state;
    logic [WIDTH-1:0] exp_q;
    logic             exp_rco;
    logic             exp_load;

    logic             q_mis, rco_mis, load_mis, any_mis;
    logic [WIDTH-1:0] base;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] pred_q;
    logic             pred_rco, pred_load;
    logic [7:0]       cnt_inc;

    assign mon_state = state;

    assign q_mis    = (Q != exp_q);
    assign rco_mis  = (rco != exp_rco);
    assign load_mis = (load != exp_load);
    assign any_mis  = q_mis | rco_mis | load_mis;
    assign cnt_inc  = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

    // In ARM the counter has already taken one step past the value loaded in IDLE,
    // so the first prediction is built on the Q seen at that edge.
    always_comb begin
        base = exp_q;
        if (state == ARM) begin
            base = Q;
        end
`ifdef MON_RESYNC_EN
        else if (q_mis) begin
            base = Q;
        end
`endif
    end

    // rco is the carry/borrow bit of the (WIDTH+1)-bit step.
    always_comb begin
        wide      = {1'b0, base};
        pred_q    = base;
        pred_rco  = 1'b0;
        pred_load = 1'b0;
        if (enable) begin
            case (mode)
                2'b00: begin
                    wide     = {1'b0, base} + THREE;
                    pred_q   = wide[WIDTH-1:0];
                    pred_rco = wide[WIDTH];
                end
                2'b01: begin
                    wide     = {1'b0, base} - ONE;
                    pred_q   = wide[WIDTH-1:0];
                    pred_rco = wide[WIDTH];
                end
                2'b10: begin
                    wide     = {1'b0, base} + ONE;
                    pred_q   = wide[WIDTH-1:0];
                    pred_rco = wide[WIDTH];
                end
                default: begin
                    pred_q    = D;
                    pred_load = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            exp_q      <= '0;
            exp_rco    <= 1'b0;
            exp_load   <= 1'b0;
            err_q      <= 1'b0;
            err_rco    <= 1'b0;
            err_load   <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            err_q    <= 1'b0;
            err_rco  <= 1'b0;
            err_load <= 1'b0;
            case (state)
                IDLE: begin
                    exp_q    <= Q;
                    exp_rco  <= 1'b0;
                    exp_load <= 1'b0;
                    state    <= ARM;
                end
                ARM: begin
                    exp_q    <= pred_q;
                    exp_rco  <= pred_rco;
                    exp_load <= pred_load;
                    state    <= TRACK;
                end
                TRACK: begin
                    exp_q    <= pred_q;
                    exp_rco  <= pred_rco;
                    exp_load <= pred_load;
                    err_q    <= q_mis;
                    err_rco  <= rco_mis;
                    err_load <= load_mis;
                    if (any_mis) begin
                        err_sticky <= 1'b1;
                        err_count  <= cnt_inc;
                        if (cnt_inc >= LIMIT) begin
                            state <= FAULT;
                        end
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
